gf3m_shift_k: RTL and testbench

Sequential GF(3^M) shift unit: multiplies a field element by x^k or x^-k modulo the trinomial x^M + x^T + 2, one trit position per clock. It generalises the fixed single-step x^-1 reduction network to a parametrised degree and tap, a selectable direction and a runtime step count, with a start/done handshake. It sits beside the GF(3^M) arithmetic units in the pairing datapath, where it serves as a shared shifter for rescaling field elements.

---
 rtl/gf3m_shift_k.sv | 114 +++++++++++
 tb/tb_gf3m_shift_k.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gf3m_shift_k.sv
`default_nettype none
// ============================================================================
//  Module   : gf3m_shift_k
//  Purpose  : Sequential GF(3^M) multiply by x^k or x^-k modulo x^M + x^T + 2,
//             one trit position per clock, with start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module gf3m_shift_k #(
    parameter int M  = 97,
    parameter int T  = 12,
    parameter int KW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            dir,
    input  logic [KW-1:0]   k,
    input  logic [2*M-1:0]  A,
    output logic [2*M-1:0]  C,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*M-1:0]  c_q, c_d;
    logic [KW-1:0]   cnt_q, cnt_d;
    logic            dir_q, dir_d;
    logic            done_q, done_d;
    logic [2*M-1:0]  step_up, step_dn;

    // GF(3) sum on the 00/01/10 encoding; inputs never carry code 11.
    function automatic logic [1:0] gf3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        logic [2:0] r;
        s = {1'b0, a} + {1'b0, b};
        r = s - 3'd3;
        return (s >= 3'd3) ? r[1:0] : s[1:0];
    endfunction

    always_comb begin
        step_up = '0;
        step_dn = '0;
        // x * C: top trit wraps to trit 0 and folds 2h into trit T.
        step_up[1:0] = c_q[2*M-1 -: 2];
        for (int i = 1; i < M; i++) begin
            step_up[2*i +: 2] = c_q[2*(i-1) +: 2];
        end
        step_up[2*T +: 2] = gf3_add(c_q[2*(T-1) +: 2],
                                    gf3_add(c_q[2*M-1 -: 2], c_q[2*M-1 -: 2]));
        // x^-1 * C: trit 0 wraps to trit M-1 and folds into trit T-1.
        step_dn[2*(M-1) +: 2] = c_q[1:0];
        for (int i = 0; i < M-1; i++) begin
            step_dn[2*i +: 2] = c_q[2*(i+1) +: 2];
        end
        step_dn[2*(T-1) +: 2] = gf3_add(c_q[2*T +: 2], c_q[1:0]);
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    c_d     = A;
                    cnt_d   = k;
                    dir_d   = dir;
                    state_d = S_RUN;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    c_d   = dir_q ? step_dn : step_up;
                    cnt_d = cnt_q - KW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign C    = c_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gf3m_shift_k.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gf3m_shift_k
//  Purpose  : Directed self-checking bench for gf3m_shift_k.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gf3m_shift_k;

    localparam int M  = 97;
    localparam int T  = 12;
    localparam int KW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            dir = 1'b0;
    logic [KW-1:0]   k = '0;
    logic [2*M-1:0]  A = '0;
    logic [2*M-1:0]  C;
    logic            busy;
    logic            done;

    int total = 0;
    int bad   = 0;

    gf3m_shift_k #(.M(M), .T(T), .KW(KW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dir   (dir),
        .k     (k),
        .A     (A),
        .C     (C),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_add(input logic [1:0] a, input logic [1:0] b);
        int s;
        s = (int'(a) + int'(b)) % 3;
        return 2'(s);
    endfunction

    function automatic logic [2*M-1:0] m_step(input logic [2*M-1:0] c, input logic d);
        logic [2*M-1:0] n;
        logic [1:0] h;
        n = '0;
        if (!d) begin
            h = c[2*M-1 -: 2];
            for (int i = 1; i < M; i++) n[2*i +: 2] = c[2*(i-1) +: 2];
            n[1:0] = h;
            n[2*T +: 2] = m_add(c[2*(T-1) +: 2], m_add(h, h));
        end else begin
            h = c[1:0];
            for (int i = 0; i < M-1; i++) n[2*i +: 2] = c[2*(i+1) +: 2];
            n[2*(M-1) +: 2] = h;
            n[2*(T-1) +: 2] = m_add(c[2*T +: 2], h);
        end
        return n;
    endfunction

    function automatic logic [2*M-1:0] m_shift(input logic [2*M-1:0] c, input int kk, input logic d);
        logic [2*M-1:0] r;
        r = c;
        for (int i = 0; i < kk; i++) r = m_step(r, d);
        return r;
    endfunction

    function automatic logic [2*M-1:0] rand_elem();
        logic [2*M-1:0] r;
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [2*M-1:0] obs, input logic [2*M-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, then waits (bounded) for done; lat=0 means timeout.
    task automatic run(input logic [2*M-1:0] a, input int kk, input logic d,
                       output int lat, output int bcnt);
        @(negedge clk);
        A = a; k = KW'(kk); dir = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    logic [2*M-1:0] a0, a1, a2, fwd, exp_c;
    int lat, bcnt, kk;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_C", C, '0);
        chk("reset_done", {193'd0, done}, '0);
        chk("reset_busy", {193'd0, busy}, '0);
        @(negedge clk);
        reset = 1'b0;

        // x^-1 of 1 = x^96 + x^11
        run(194'd1, 1, 1'b1, lat, bcnt);
        exp_c = '0;
        exp_c[193:192] = 2'b01;
        exp_c[23:22]   = 2'b01;
        chk("inv1_C", C, exp_c);
        chk("inv1_lat", 194'(lat), 194'd2);

        // x^97 = 2x^12 + 1
        run(194'd1, 97, 1'b0, lat, bcnt);
        exp_c = '0;
        exp_c[25:24] = 2'b10;
        exp_c[1:0]   = 2'b01;
        chk("x97_C", C, exp_c);
        chk("x97_lat", 194'(lat), 194'd98);
        chk("x97_busy", 194'(bcnt), 194'd98);

        // C and done hold in DONE
        repeat (5) @(posedge clk);
        #1;
        chk("hold_C", C, exp_c);
        chk("hold_done", {193'd0, done}, 194'd1);

        // k=0: one cycle latency, C==A, busy exactly one cycle
        a0 = rand_elem();
        run(a0, 0, 1'b0, lat, bcnt);
        chk("k0_C", C, a0);
        chk("k0_lat", 194'(lat), 194'd1);
        chk("k0_busy", 194'(bcnt), 194'd1);

        // Random forward against model, then round trip back
        for (int r = 0; r < 24; r++) begin
            a0 = rand_elem();
            kk = (r == 23) ? 255 : ((r == 0) ? 37 : int'($urandom_range(1, 120)));
            run(a0, kk, 1'b0, lat, bcnt);
            fwd = C;
            chk("rt_fwd_C", fwd, m_shift(a0, kk, 1'b0));
            chk("rt_fwd_lat", 194'(lat), 194'(kk + 1));
            run(fwd, kk, 1'b1, lat, bcnt);
            chk("rt_back_C", C, a0);
        end

        // Second start while RUN is ignored
        a1 = rand_elem();
        a2 = rand_elem();
        @(negedge clk);
        A = a1; k = 8'd20; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 5) begin
                @(negedge clk);
                A = a2; k = 8'd3; dir = 1'b1; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("ign_lat", 194'(lat), 194'd21);
        chk("ign_C", C, m_shift(a1, 20, 1'b0));

        // Reset in the middle of an operation
        @(negedge clk);
        A = rand_elem(); k = 8'd10; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid_rst_C", C, '0);
        chk("mid_rst_done", {193'd0, done}, '0);
        chk("mid_rst_busy", {193'd0, busy}, '0);
        run(194'd1, 1, 1'b0, lat, bcnt);
        chk("post_rst_C", C, 194'd4);
        chk("post_rst_lat", 194'(lat), 194'd2);

        // Reset wins over simultaneous start
        @(negedge clk);
        A = rand_elem(); k = 8'd5; dir = 1'b0; start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        chk("rst_start_busy", {193'd0, busy}, '0);
        chk("rst_start_C", C, '0);
        @(posedge clk); #1;
        chk("rst_start_idle", {192'd0, busy, done}, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
